config_register: RTL and testbench

Holds the 5-bit operating-mode word for the DSP accelerator datapath. It captures `config_in` on a clock edge while `write_enable` is high and otherwise holds its value. It drives the stored word on `config_mode` to downstream mode-select logic. It also raises a one-cycle `config_updated` strobe so consumers can re-arm when the mode is rewritten.

---
 rtl/config_register.sv | 43 ++++
 tb/tb_config_register.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/config_register.sv
// config_register: holds the operating-mode word for the DSP accelerator
// datapath. It loads config_in on every rising edge with write_enable high.
// It also raises config_updated for the cycle that follows each accepted write.
module config_register #(
    parameter int unsigned      WIDTH       = 5,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,          // synchronous, active-low
    input  logic             write_enable,
    input  logic [WIDTH-1:0] config_in,
    output logic [WIDTH-1:0] config_mode,
    output logic             config_updated
);

    logic [WIDTH-1:0] mode_q, mode_d;
    logic             updated_q, updated_d;

    // Next-state: a write loads the word verbatim and arms the strobe; the strobe drops otherwise.
    always_comb begin
        mode_d    = mode_q;
        updated_d = 1'b0;
        if (write_enable) begin
            mode_d    = config_in;
            updated_d = 1'b1;
        end
    end

    // State register; reset takes priority over a simultaneous write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q    <= RESET_VALUE;
            updated_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            updated_q <= updated_d;
        end
    end

    assign config_mode    = mode_q;
    assign config_updated = updated_q;

endmodule

// File: tb/tb_config_register.sv
// Self-checking bench for config_register. It runs the directed test plan
// and then randomized traffic against a behavioural model. A second instance
// with a non-zero RESET_VALUE checks that the parameter is honoured.
module tb_config_register;

    localparam int unsigned      W     = 5;
    localparam logic [W-1:0]     RV_B  = 5'b10110;

    logic         clk = 1'b0;
    logic         reset;
    logic         write_enable;
    logic [W-1:0] config_in;
    logic [W-1:0] mode_a, mode_b;
    logic         upd_a, upd_b;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model state.
    logic [W-1:0] exp_mode_a, exp_mode_b;
    logic         exp_upd;

    always #5 clk = ~clk;

    config_register #(.WIDTH(W)) dut_a (
        .clk            (clk),
        .reset          (reset),
        .write_enable   (write_enable),
        .config_in      (config_in),
        .config_mode    (mode_a),
        .config_updated (upd_a)
    );

    config_register #(.WIDTH(W), .RESET_VALUE(RV_B)) dut_b (
        .clk            (clk),
        .reset          (reset),
        .write_enable   (write_enable),
        .config_in      (config_in),
        .config_mode    (mode_b),
        .config_updated (upd_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behaviour after one rising edge, in the terms of the register's description.
    task automatic model_edge(input logic rst_n, input logic we, input logic [W-1:0] din);
        if (!rst_n) begin
            exp_mode_a = '0;
            exp_mode_b = RV_B;
            exp_upd    = 1'b0;
        end else if (we) begin
            exp_mode_a = din;
            exp_mode_b = din;
            exp_upd    = 1'b1;
        end else begin
            exp_upd    = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".mode_a"}, 32'(mode_a), 32'(exp_mode_a));
        check({tag, ".mode_b"}, 32'(mode_b), 32'(exp_mode_b));
        check({tag, ".upd_a"},  32'(upd_a),  32'(exp_upd));
        check({tag, ".upd_b"},  32'(upd_b),  32'(exp_upd));
    endtask

    // Drive inputs on the falling edge, clock once, update the model and compare.
    task automatic step(input string tag, input logic rst_n, input logic we, input logic [W-1:0] din);
        @(negedge clk);
        reset        = rst_n;
        write_enable = we;
        config_in    = din;
        @(posedge clk);
        model_edge(rst_n, we, din);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset        = 1'b1;
        write_enable = 1'b0;
        config_in    = '0;

        // Reset with a write pending: reset wins.
        step("reset", 1'b0, 1'b1, 5'b11111);

        // Single write, then its strobe drops while the value holds.
        step("wr1",     1'b1, 1'b1, 5'b00011);
        step("wr1_idle",1'b1, 1'b0, 5'b00011);

        // Hold: input changes without write_enable have no effect.
        for (int i = 0; i < 3; i++) step("hold", 1'b1, 1'b0, 5'b10101);

        // Sequence: write, idle, write.
        step("seq_w1",  1'b1, 1'b1, 5'b10101);
        step("seq_idle",1'b1, 1'b0, 5'b00000);
        step("seq_w2",  1'b1, 1'b1, 5'b11111);
        step("seq_end", 1'b1, 1'b0, 5'b00000);

        // Back-to-back writes keep the strobe high.
        step("b2b_0", 1'b1, 1'b1, 5'b00001);
        step("b2b_1", 1'b1, 1'b1, 5'b00010);
        step("b2b_2", 1'b1, 1'b1, 5'b00100);
        step("b2b_end", 1'b1, 1'b0, 5'b00000);

        // Rewrite same value still pulses.
        step("same_0", 1'b1, 1'b1, 5'b11111);
        step("same_1", 1'b1, 1'b1, 5'b11111);

        // Reset is synchronous: lowering it between edges changes nothing yet.
        @(negedge clk);
        reset        = 1'b0;
        write_enable = 1'b1;
        config_in    = 5'b01010;
        #2;
        check_all("rst_sync");
        @(posedge clk);
        model_edge(1'b0, 1'b1, 5'b01010);
        #1;
        check_all("rst_mid");

        // After release, a new write loads normally.
        step("post_rst", 1'b1, 1'b1, 5'b01010);
        step("post_idle",1'b1, 1'b0, 5'b00000);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic         r_n;
            logic         we;
            logic [W-1:0] d;
            r_n = ($urandom_range(0, 19) != 0);
            we  = ($urandom_range(0, 1) == 1);
            d   = W'($urandom);
            step("rand", r_n, we, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
